// File: rtl/regfile_dual_if.sv
// Bus between dual-issue decode/issue, writeback and the register file:
// two write ports, four read ports and two scoreboard set ports.
interface regfile_dual_if #(
    parameter int unsigned NREG = 32,
    parameter int unsigned DW   = 32
);
    localparam int unsigned AW = $clog2(NREG);

    logic                  wen0;
    logic                  wen1;
    logic [AW-1:0]         wr_addr0;
    logic [AW-1:0]         wr_addr1;
    logic [DW-1:0]         wr_data0;
    logic [DW-1:0]         wr_data1;
    logic [3:0][AW-1:0]    rd_addr;
    logic [3:0][DW-1:0]    rd_data;
    logic [3:0]            rd_busy;
    logic [1:0]            set_en;
    logic [1:0][AW-1:0]    set_addr;
    logic                  flush;

    modport master (
        output wen0, wen1, wr_addr0, wr_addr1, wr_data0, wr_data1,
        output rd_addr, set_en, set_addr, flush,
        input  rd_data, rd_busy
    );

    modport slave (
        input  wen0, wen1, wr_addr0, wr_addr1, wr_data0, wr_data1,
        input  rd_addr, set_en, set_addr, flush,
        output rd_data, rd_busy
    );
endinterface

// File: rtl/regfile_dual.sv
// Dual-write, four-read register file with same-cycle write bypass and a
// write-pending scoreboard. Register 0 is hardwired to zero and never busy.
module regfile_dual #(
    parameter int unsigned NREG = 32,
    parameter int unsigned DW   = 32
) (
    input logic           clk,
    input logic           reset,
    regfile_dual_if.slave bus
);
    localparam int unsigned AW = $clog2(NREG);

    logic [DW-1:0] regs_q [1:NREG-1];
    logic [DW-1:0] regs_d [1:NREG-1];
    logic [NREG-1:1] busy_q;
    logic [NREG-1:1] busy_d;

    logic [3:0][DW-1:0] rd_data_c;
    logic [3:0]         rd_busy_c;
    logic [3:0]         rd_valid;
    logic [3:0]         rd_hit0;
    logic [3:0]         rd_hit1;

    // Addresses of 0 or >= NREG never match r, so they neither write nor set.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int unsigned r = 1; r < NREG; r++) begin
            if (bus.wen0 && bus.wr_addr0 == AW'(r)) begin
                regs_d[r] = bus.wr_data0;
                busy_d[r] = 1'b0;
            end
            if (bus.wen1 && bus.wr_addr1 == AW'(r)) begin
                regs_d[r] = bus.wr_data1;
                busy_d[r] = 1'b0;
            end
            // A new producer supersedes the one retiring this cycle.
            if ((bus.set_en[0] && bus.set_addr[0] == AW'(r)) ||
                (bus.set_en[1] && bus.set_addr[1] == AW'(r))) begin
                busy_d[r] = 1'b1;
            end
            if (bus.flush) begin
                busy_d[r] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned r = 1; r < NREG; r++) begin
                regs_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    // Port 1 is the younger write, so its bypass takes precedence.
    always_comb begin
        rd_data_c = '0;
        rd_busy_c = '0;
        rd_valid  = '0;
        rd_hit0   = '0;
        rd_hit1   = '0;
        for (int k = 0; k < 4; k++) begin
            for (int unsigned r = 1; r < NREG; r++) begin
                if (bus.rd_addr[k] == AW'(r)) begin
                    rd_valid[k]  = 1'b1;
                    rd_data_c[k] = regs_q[r];
                    rd_busy_c[k] = busy_q[r];
                end
            end
            rd_hit1[k] = rd_valid[k] && bus.wen1 && (bus.wr_addr1 == bus.rd_addr[k]);
            rd_hit0[k] = rd_valid[k] && bus.wen0 && (bus.wr_addr0 == bus.rd_addr[k]);
            if (rd_hit1[k]) begin
                rd_data_c[k] = bus.wr_data1;
                rd_busy_c[k] = 1'b0;
            end else if (rd_hit0[k]) begin
                rd_data_c[k] = bus.wr_data0;
                rd_busy_c[k] = 1'b0;
            end
        end
    end

    assign bus.rd_data = rd_data_c;
    assign bus.rd_busy = rd_busy_c;
endmodule

// File: tb/tb_regfile_dual.sv
// Directed bench for regfile_dual: reset, bypass, write conflict, r0,
// scoreboard set/clear and flush/reset priority.
module tb_regfile_dual;
    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    regfile_dual_if #(.NREG(32), .DW(32)) rf ();

    regfile_dual #(.NREG(32), .DW(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (rf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rf.wen0     = 1'b0;
        rf.wen1     = 1'b0;
        rf.wr_addr0 = '0;
        rf.wr_addr1 = '0;
        rf.wr_data0 = '0;
        rf.wr_data1 = '0;
        rf.set_en   = '0;
        rf.set_addr = '0;
        rf.flush    = 1'b0;
    endtask

    initial begin
        idle();
        rf.rd_addr = '0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // 1: everything reads zero and idle after reset
        for (int a = 1; a < 32; a++) begin
            for (int k = 0; k < 4; k++) rf.rd_addr[k] = 5'(a);
            #1;
            for (int k = 0; k < 4; k++) begin
                check($sformatf("reset_data r%0d p%0d", a, k), rf.rd_data[k], 32'h0);
                check($sformatf("reset_busy r%0d p%0d", a, k), 32'(rf.rd_busy[k]), 32'h0);
            end
        end

        // 2: write r5, bypass then storage
        rf.rd_addr  = '0;
        rf.rd_addr[0] = 5'd5;
        rf.wen0     = 1'b1;
        rf.wr_addr0 = 5'd5;
        rf.wr_data0 = 32'hDEADBEEF;
        #1 check("wr_bypass r5", rf.rd_data[0], 32'hDEADBEEF);
        tick();
        idle();
        #1 check("wr_storage r5", rf.rd_data[0], 32'hDEADBEEF);

        // 3: both ports write r7, port 1 wins
        rf.rd_addr[1] = 5'd7;
        rf.wen0     = 1'b1;
        rf.wr_addr0 = 5'd7;
        rf.wr_data0 = 32'h11111111;
        rf.wen1     = 1'b1;
        rf.wr_addr1 = 5'd7;
        rf.wr_data1 = 32'h22222222;
        #1 check("conflict_bypass r7", rf.rd_data[1], 32'h22222222);
        tick();
        idle();
        #1 check("conflict_storage r7", rf.rd_data[1], 32'h22222222);

        // 4: register zero ignores write and set
        rf.rd_addr[3] = 5'd0;
        rf.wen1     = 1'b1;
        rf.wr_addr1 = 5'd0;
        rf.wr_data1 = 32'hFFFFFFFF;
        rf.set_en[0]   = 1'b1;
        rf.set_addr[0] = 5'd0;
        #1;
        check("r0_data_same", rf.rd_data[3], 32'h0);
        check("r0_busy_same", 32'(rf.rd_busy[3]), 32'h0);
        tick();
        idle();
        #1;
        check("r0_data_next", rf.rd_data[3], 32'h0);
        check("r0_busy_next", 32'(rf.rd_busy[3]), 32'h0);

        // 5: scoreboard on r9
        rf.rd_addr[2]  = 5'd9;
        rf.set_en[0]   = 1'b1;
        rf.set_addr[0] = 5'd9;
        #1 check("sb_set_same r9", 32'(rf.rd_busy[2]), 32'h0);
        tick();
        idle();
        #1 check("sb_set_next r9", 32'(rf.rd_busy[2]), 32'h1);
        rf.wen1     = 1'b1;
        rf.wr_addr1 = 5'd9;
        rf.wr_data1 = 32'h00001234;
        #1;
        check("sb_wr_busy r9", 32'(rf.rd_busy[2]), 32'h0);
        check("sb_wr_data r9", rf.rd_data[2], 32'h00001234);
        tick();
        idle();
        #1;
        check("sb_cleared r9", 32'(rf.rd_busy[2]), 32'h0);
        check("sb_stored r9", rf.rd_data[2], 32'h00001234);
        rf.set_en[1]   = 1'b1;
        rf.set_addr[1] = 5'd9;
        rf.wen0     = 1'b1;
        rf.wr_addr0 = 5'd9;
        rf.wr_data0 = 32'h00005678;
        #1;
        check("sb_setwr_busy_same r9", 32'(rf.rd_busy[2]), 32'h0);
        check("sb_setwr_data_same r9", rf.rd_data[2], 32'h00005678);
        tick();
        idle();
        #1;
        check("sb_setwr_busy_next r9", 32'(rf.rd_busy[2]), 32'h1);
        check("sb_setwr_data_next r9", rf.rd_data[2], 32'h00005678);

        // 6: flush and reset priority
        rf.wen0     = 1'b1;
        rf.wr_addr0 = 5'd3;
        rf.wr_data0 = 32'h000000A3;
        rf.wen1     = 1'b1;
        rf.wr_addr1 = 5'd4;
        rf.wr_data1 = 32'h000000B4;
        tick();
        idle();
        rf.set_en   = 2'b11;
        rf.set_addr[0] = 5'd3;
        rf.set_addr[1] = 5'd4;
        tick();
        idle();
        rf.rd_addr[0] = 5'd3;
        rf.rd_addr[1] = 5'd4;
        rf.rd_addr[2] = 5'd6;
        rf.rd_addr[3] = 5'd9;
        #1;
        check("fl_pre_busy r3", 32'(rf.rd_busy[0]), 32'h1);
        check("fl_pre_busy r4", 32'(rf.rd_busy[1]), 32'h1);
        rf.flush       = 1'b1;
        rf.set_en[0]   = 1'b1;
        rf.set_addr[0] = 5'd6;
        tick();
        idle();
        #1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("fl_busy p%0d", k), 32'(rf.rd_busy[k]), 32'h0);
        end
        check("fl_data r3", rf.rd_data[0], 32'h000000A3);
        check("fl_data r4", rf.rd_data[1], 32'h000000B4);
        check("fl_data r9", rf.rd_data[3], 32'h00005678);
        rf.set_en[0]   = 1'b1;
        rf.set_addr[0] = 5'd4;
        reset       = 1'b1;
        rf.wen0     = 1'b1;
        rf.wr_addr0 = 5'd3;
        rf.wr_data0 = 32'h00000055;
        #1 check("rst_bypass r3", rf.rd_data[0], 32'h00000055);
        tick();
        reset = 1'b0;
        idle();
        #1;
        check("rst_data r3", rf.rd_data[0], 32'h0);
        check("rst_data r4", rf.rd_data[1], 32'h0);
        check("rst_busy r4", 32'(rf.rd_busy[1]), 32'h0);
        check("rst_data r9", rf.rd_data[3], 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/regfile_dual.md
# regfile_dual

Dual-write, four-read MIPS general-purpose register file with a write-pending scoreboard. It sits between the dual-issue decode/issue stage, which uses the read ports and marks destinations pending, and the writeback stage, which drives the two write ports. Same-cycle writes are bypassed to the read ports, so writeback-to-decode forwarding needs no extra cycle.

## Interface
Parameters:
- `NREG`, 32: number of architectural registers. `$clog2(NREG)` sets the address width, 5 at the default.
- `DW`, 32: data width.

Ports:
- `clk`  in  1: single clock. All state updates on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `wen0` / `wen1`  in  1 each: write enables. Port 0 is the older slot; port 1 is the younger slot.
- `wr_addr0` / `wr_addr1`  in  5 each: write addresses.
- `wr_data0` / `wr_data1`  in  DW each: write data.
- `rd_addr[3:0]`  in  4×5: read addresses. Ports 0/1 serve slot 0 rs/rt; ports 2/3 serve slot 1 rs/rt.
- `rd_data[3:0]`  out  4×DW: read data, combinational.
- `rd_busy[3:0]`  out  4×1: 1 when the addressed register has a pending, unretired producer.
- `set_en[1:0]`  in  2: issue marks a destination pending. Index 0 is slot 0; index 1 is slot 1.
- `set_addr[1:0]`  in  2×5: destinations being marked pending.
- `flush`  in  1: clears every busy bit. Register contents are kept.

## Operation
Storage and writes:
- Storage `regs[1..31]`. Register 0 is not stored; it always reads 0 and is never busy.
- A write commits at the edge when `wenN` is 1 and `wr_addrN` is nonzero.
- `wen0` and `wen1` to the same address in one cycle: port 1 data wins.

Reads, per port, evaluated in priority order:
1. `rd_addr` is 0: `rd_data` = 0.
2. `wen1` is 1 and `wr_addr1` matches: `rd_data` = `wr_data1`.
3. `wen0` is 1 and `wr_addr0` matches: `rd_data` = `wr_data0`.
4. Otherwise: `rd_data` = `regs[addr]`.

Scoreboard:
- `busy[31:1]`, next-state per register r in priority order:
  1. `reset`: 0.
  2. `flush`: 0.
  3. Any `set_en[i]` with `set_addr[i]` = r: 1. A set overrides a simultaneous clear of r, because a new producer supersedes the retiring one.
  4. Any write to r this cycle: 0.
  5. Otherwise: hold.
- `rd_busy[k]` = `busy[rd_addr[k]]`, but forced to 0 when the same-cycle bypass in steps 2–3 hits that address. Data is then available, so the reader must not stall.
- `set_en` with `set_addr` = 0 is ignored.
- `flush` and `set_en` in the same cycle: flush wins, and no bit is set.

Reset:
- All `regs` = 0 and all `busy` = 0.
- Reset asserted mid-operation discards writes and sets presented in that same cycle.
- Outputs after reset: `rd_data` = 0 and `rd_busy` = 0 for every address, unless a same-cycle bypass hit applies.

Width rules:
- Addresses at or above `NREG` cannot occur at the default parameters. If they occur with `NREG` < 32, they are treated as register 0.

## Timing
- Read path is zero-latency combinational: address, plus any same-cycle write, gives data in the same cycle.
- Write visibility:
  - Cycle N: visible through the bypass.
  - Cycle N+1 onward: visible from storage.
- Busy latency:
  - A set in cycle N raises `rd_busy` from cycle N+1.
  - A clear by a write in cycle N drops `rd_busy` in cycle N via the bypass mask, and in storage from N+1.
- There is no handshake; the block never backpressures. Callers guarantee at most two writes and two sets per cycle.
- The only inter-port ordering is the port-1-over-port-0 priority described under Operation.

## Test plan
1. Reset sequence: assert `reset` for 2 cycles, release, read r1..r31 on all ports. Required: every `rd_data` = 0 and every `rd_busy` = 0.
2. Write then read: `wen0`=1, `wr_addr0`=5, `wr_data0`=0xDEADBEEF in cycle N, with `rd_addr[0]`=5 in cycles N and N+1. Required: 0xDEADBEEF in both cycles, via bypass in N and storage in N+1.
3. Write conflict: `wen0`/`wen1` both to r7 with 0x11111111 / 0x22222222. Required: same-cycle read returns 0x22222222, and the next-cycle read returns 0x22222222.
4. Register zero: `wen1`=1, `wr_addr1`=0, `wr_data1`=0xFFFFFFFF, `set_en[0]`=1 with `set_addr[0]`=0. Required: reading r0 gives 0 and `rd_busy`=0, in the same and following cycles.
5. Scoreboard:
   - Set r9 in cycle N: `rd_busy` for r9 is 1 from N+1.
   - Write r9 with 0x1234 in cycle M: `rd_busy`=0 and `rd_data`=0x1234 in M.
   - Set r9 and write r9 in the same cycle: `busy` = 1 afterwards.
6. Flush and reset priority:
   - Set r3 and r4, then pulse `flush` together with a set of r6. Required: all `rd_busy` = 0 next cycle, and r3/r4 data unchanged.
   - Then assert `reset` together with a write of r3 = 0x55. Required: r3 reads 0 afterwards.
